// File: rtl/ps2_space_key_if.sv
// PS/2 receiver bus: raw keyboard lines in, decoded space level and byte status out.
interface ps2_space_key_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic       space;
  logic [7:0] scan_code;
  logic       code_valid;
  logic       frame_err;

  modport master (
    output ps2_clk, ps2_data,
    input  space, scan_code, code_valid, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output space, scan_code, code_valid, frame_err
  );
endinterface

// File: rtl/ps2_space_key.sv
// PS/2 keyboard receiver: synchronise, glitch-filter, deframe 11-bit frames,
// and decode make/break sequences of the space bar into a clean level.
module ps2_space_key #(
  parameter int         FILTER_LEN     = 8,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter logic [7:0] SPACE_CODE     = 8'h29
) (
  input  logic           clk,
  input  logic           reset,
  ps2_space_key_if.slave bus
);
  localparam int FCNT_W = $clog2(FILTER_LEN + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0] raw_in;
  logic [1:0] sync_in;
  assign raw_in = {bus.ps2_data, bus.ps2_clk};

  // Both lines idle high, so the synchronisers reset to 1 to avoid a false edge.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;
      always_ff @(posedge clk) begin
        if (reset) begin
          meta_reg <= 1'b1;
          sync_reg <= 1'b1;
        end else begin
          meta_reg <= raw_in[gi];
          sync_reg <= meta_reg;
        end
      end
      assign sync_in[gi] = sync_reg;
    end
  endgenerate

  logic [FCNT_W-1:0] fcnt_reg;
  logic              filt_reg;
  logic              filt_d_reg;
  logic              strike;
  logic              data_bit;

  always_ff @(posedge clk) begin
    if (reset) begin
      fcnt_reg   <= '0;
      filt_reg   <= 1'b1;
      filt_d_reg <= 1'b1;
    end else begin
      filt_d_reg <= filt_reg;
      if (sync_in[0] == filt_reg) begin
        fcnt_reg <= '0;
      end else if (fcnt_reg == FCNT_W'(FILTER_LEN - 1)) begin
        filt_reg <= sync_in[0];
        fcnt_reg <= '0;
      end else begin
        fcnt_reg <= fcnt_reg + FCNT_W'(1);
      end
    end
  end

  assign strike   = filt_d_reg & ~filt_reg;
  assign data_bit = sync_in[1];

  state_t           state_reg;
  logic [2:0]       bitcnt_reg;
  logic [7:0]       shift_reg;
  logic             parity_reg;
  logic [7:0]       scan_code_reg;
  logic             code_valid_reg;
  logic             frame_err_reg;
  logic [TMO_W-1:0] tmo_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      bitcnt_reg     <= '0;
      shift_reg      <= '0;
      parity_reg     <= 1'b0;
      scan_code_reg  <= '0;
      code_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      tmo_reg        <= '0;
    end else begin
      code_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;

      if (state_reg == IDLE || strike) begin
        tmo_reg <= '0;
      end else begin
        tmo_reg <= tmo_reg + TMO_W'(1);
      end

      case (state_reg)
        IDLE: begin
          if (strike) begin
            if (!data_bit) begin
              state_reg  <= DATA;
              bitcnt_reg <= '0;
            end else begin
              frame_err_reg <= 1'b1;
            end
          end
        end
        DATA: begin
          if (strike) begin
            shift_reg  <= {data_bit, shift_reg[7:1]};
            bitcnt_reg <= bitcnt_reg + 3'd1;
            if (bitcnt_reg == 3'd7) begin
              state_reg <= PARITY;
            end
          end
        end
        PARITY: begin
          if (strike) begin
            parity_reg <= data_bit;
            state_reg  <= STOP;
          end
        end
        STOP: begin
          if (strike) begin
            if (data_bit && (^{shift_reg, parity_reg})) begin
              scan_code_reg  <= shift_reg;
              code_valid_reg <= 1'b1;
            end else begin
              frame_err_reg <= 1'b1;
            end
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase

      // A strike in the same cycle wins over an expiring timeout.
      if (state_reg != IDLE && !strike && tmo_reg == TMO_W'(TIMEOUT_CYCLES - 1)) begin
        frame_err_reg <= 1'b1;
        state_reg     <= IDLE;
        shift_reg     <= '0;
      end
    end
  end

  logic space_reg;
  logic brk_pend_reg;
  logic ext_pend_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      space_reg    <= 1'b0;
      brk_pend_reg <= 1'b0;
      ext_pend_reg <= 1'b0;
    end else if (code_valid_reg) begin
      case (scan_code_reg)
        8'hF0: brk_pend_reg <= 1'b1;
        8'hE0: ext_pend_reg <= 1'b1;
        default: begin
          if (scan_code_reg == SPACE_CODE && !ext_pend_reg) begin
            space_reg <= ~brk_pend_reg;
          end
          brk_pend_reg <= 1'b0;
          ext_pend_reg <= 1'b0;
        end
      endcase
    end else if (frame_err_reg) begin
      brk_pend_reg <= 1'b0;
      ext_pend_reg <= 1'b0;
    end
  end

  assign bus.space      = space_reg;
  assign bus.scan_code  = scan_code_reg;
  assign bus.code_valid = code_valid_reg;
  assign bus.frame_err  = frame_err_reg;
endmodule

// File: tb/tb_ps2_space_key.sv
// Bench for ps2_space_key: table of PS/2 frames with a scoreboard of expected
// byte/error events, plus timeout, glitch and mid-frame reset sequences.
module tb_ps2_space_key;
  localparam int HALF   = 20;
  localparam int SETTLE = 30;
  localparam int TMO    = 2000;
  localparam int NVEC   = 18;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ps2_space_key_if bus ();

  ps2_space_key #(
    .FILTER_LEN    (8),
    .TIMEOUT_CYCLES(TMO),
    .SPACE_CODE    (8'h29)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [7:0] data;
    bit         flip_par;
    bit         bad_stop;
    bit         glitch;
    bit         exp_err;
    bit         exp_space;
  } vec_t;

  typedef struct {
    bit         err;
    logic [7:0] code;
    bit         space;
  } exp_t;

  exp_t       sb_q[$];
  vec_t       vecs[NVEC];
  int         checks = 0;
  int         errors = 0;
  int         ev_cnt = 0;
  bit         chk_space_pend = 1'b0;
  bit         exp_space_next = 1'b0;
  logic [7:0] last_good = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every code_valid/frame_err pulse pops one expected event;
  // space must reflect that event exactly one cycle later.
  always @(negedge clk) begin
    if (reset) begin
      chk_space_pend = 1'b0;
    end else begin
      if (chk_space_pend) begin
        check("space_latency", 32'(bus.space), 32'(exp_space_next));
        chk_space_pend = 1'b0;
      end
      if (bus.code_valid || bus.frame_err) begin
        exp_t e;
        ev_cnt++;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got code_valid=%0b frame_err=%0b expected none at %0t",
                   bus.code_valid, bus.frame_err, $time);
        end else begin
          e = sb_q.pop_front();
          if (e.err) begin
            check("event_kind_err", {30'd0, bus.frame_err, bus.code_valid}, 32'h2);
          end else begin
            check("event_kind_ok", {30'd0, bus.frame_err, bus.code_valid}, 32'h1);
            check("event_code", 32'(bus.scan_code), 32'(e.code));
          end
          chk_space_pend = 1'b1;
          exp_space_next = e.space;
        end
      end
    end
  end

  task automatic send_frame(input logic [7:0] d, input bit flip_par, input bit bad_stop,
                            input bit glitch, input int nbits);
    logic [10:0] fr;
    fr = {~bad_stop, (~^d) ^ flip_par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      bus.ps2_data = fr[i];
      repeat (HALF / 2) @(negedge clk);
      if (glitch) begin
        bus.ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        bus.ps2_clk = 1'b1;
      end
      repeat (HALF / 2) @(negedge clk);
      bus.ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      bus.ps2_clk = 1'b1;
    end
    bus.ps2_data = 1'b1;
  endtask

  task automatic push_exp(input bit err, input logic [7:0] code, input bit space);
    exp_t e;
    e.err   = err;
    e.code  = code;
    e.space = space;
    sb_q.push_back(e);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_space"}, 32'(bus.space), 32'd0);
    check({tag, "_scan_code"}, 32'(bus.scan_code), 32'd0);
    check({tag, "_code_valid"}, 32'(bus.code_valid), 32'd0);
    check({tag, "_frame_err"}, 32'(bus.frame_err), 32'd0);
  endtask

  initial begin
    int ev_before;

    //          data   flip bstop glitch err space
    vecs[0]  = '{8'h29, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{8'h29, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{8'h29, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{8'h29, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{8'h1C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{8'h29, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{8'h29, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{8'h29, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{8'h29, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{8'h29, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{8'hF0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[16] = '{8'h29, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{8'h5A, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    reset        = 1'b1;
    repeat (5) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < NVEC; i++) begin
      push_exp(vecs[i].exp_err, vecs[i].data, vecs[i].exp_space);
      send_frame(vecs[i].data, vecs[i].flip_par, vecs[i].bad_stop, vecs[i].glitch, 11);
      repeat (SETTLE) @(negedge clk);
      if (!vecs[i].exp_err) last_good = vecs[i].data;
      check("space_settled", 32'(bus.space), 32'(vecs[i].exp_space));
      check("scan_code_held", 32'(bus.scan_code), 32'(last_good));
      $display("frame %0d data=%02h flip=%0b bad_stop=%0b glitch=%0b space=%0b scan_code=%02h",
               i, vecs[i].data, vecs[i].flip_par, vecs[i].bad_stop, vecs[i].glitch,
               bus.space, bus.scan_code);
    end

    // Truncated frame: start plus 4 data bits, then silence until the timeout fires.
    ev_before = ev_cnt;
    push_exp(1'b1, last_good, 1'b0);
    send_frame(8'h29, 1'b0, 1'b0, 1'b0, 5);
    repeat (TMO - 300) @(negedge clk);
    check("timeout_not_early", ev_cnt - ev_before, 0);
    repeat (500) @(negedge clk);
    check("timeout_pulses", ev_cnt - ev_before, 1);
    check("timeout_space", 32'(bus.space), 32'd0);
    check("timeout_scan_code", 32'(bus.scan_code), 32'(last_good));
    $display("timeout sequence: events=%0d space=%0b", ev_cnt - ev_before, bus.space);
    push_exp(1'b0, 8'h29, 1'b1);
    send_frame(8'h29, 1'b0, 1'b0, 1'b0, 11);
    repeat (SETTLE) @(negedge clk);
    last_good = 8'h29;
    check("after_timeout_space", 32'(bus.space), 32'd1);
    $display("post-timeout frame data=29 space=%0b scan_code=%02h", bus.space, bus.scan_code);

    // Short ps2_clk glitches on an idle bus must never produce a strike.
    ev_before = ev_cnt;
    for (int g = 0; g < 6; g++) begin
      bus.ps2_clk = 1'b0;
      repeat (3) @(negedge clk);
      bus.ps2_clk = 1'b1;
      repeat (10) @(negedge clk);
    end
    repeat (50) @(negedge clk);
    check("glitch_no_pulse", ev_cnt - ev_before, 0);
    check("glitch_space", 32'(bus.space), 32'd1);
    $display("glitch sequence: events=%0d space=%0b", ev_cnt - ev_before, bus.space);

    // Reset in the middle of a frame, then a clean frame must deframe normally.
    send_frame(8'h29, 1'b0, 1'b0, 1'b0, 4);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_outputs_zero("midframe_reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    push_exp(1'b0, 8'h29, 1'b1);
    send_frame(8'h29, 1'b0, 1'b0, 1'b0, 11);
    repeat (SETTLE) @(negedge clk);
    check("after_reset_space", 32'(bus.space), 32'd1);
    check("after_reset_scan_code", 32'(bus.scan_code), 32'h29);
    $display("post-reset frame data=29 space=%0b scan_code=%02h", bus.space, bus.scan_code);

    repeat (50) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
